iob_cache_front_arbiter: RTL and testbench
==========================================

Name: iob_cache_front_arbiter

Overview:
- Two-requester round-robin arbiter that shares one cache front-end port (req/ack native interface) between two masters, e.g. instruction and data buses.
- Sits directly in front of the cache front-end.
- Forwards the granted request, steers ack back to the owner, and holds a captured copy of the request until the cache acks.

Parameters:
ADDR_W, 32, word address width seen by the cache data path
DATA_W, 32, data width
NBYTES, DATA_W/8, strobe width (derived, do not change)
USE_CTRL, 0, 1 adds the cache-control select MSB to the address (address width USE_CTRL+ADDR_W)

Ports:
clk_i  in  1  clock
reset_n  in  1  asynchronous active-low reset
r0_req_i  in  1  requester 0 request; held until r0_ack_o
r0_addr_i  in  USE_CTRL+ADDR_W  requester 0 address
r0_wdata_i  in  DATA_W  requester 0 write data
r0_wstrb_i  in  NBYTES  requester 0 byte strobes (0 = read)
r0_rdata_o  out  DATA_W  read data (driven from c_rdata_i)
r0_ack_o  out  1  one-cycle completion pulse
r1_req_i, r1_addr_i, r1_wdata_i, r1_wstrb_i, r1_rdata_o, r1_ack_o: same as r0 for requester 1
c_req_o  out  1  request to cache front-end
c_addr_o  out  USE_CTRL+ADDR_W  forwarded address
c_wdata_o  out  DATA_W  forwarded write data
c_wstrb_o  out  NBYTES  forwarded strobes
c_rdata_i  in  DATA_W  cache read data
c_ack_i  in  1  cache completion pulse

Behaviour:
- States: IDLE, BUSY. Registers: state, owner (1 bit), prio (1 bit, requester with priority on a tie), captured addr/wdata/wstrb.
- Reset (reset_n=0, async): state=IDLE, prio=0, owner=0, captures=0.
  - All outputs 0: c_req_o, c_addr_o, c_wdata_o, c_wstrb_o, r*_ack_o, r*_rdata_o.
- IDLE, no requests: c_req_o=0, c_addr_o/c_wdata_o/c_wstrb_o=0.
- IDLE, grant selection (combinational, same cycle as request):
  - Only r0_req_i: grant r0.
  - Only r1_req_i: grant r1.
  - Both: grant prio.
- Grant cycle:
  - c_req_o=1; c_addr/wdata/wstrb pass through from the granted requester in the same cycle (zero added latency).
  - owner and captures load with the granted requester and its signals.
  - If c_ack_i=0: go to BUSY.
  - If c_ack_i=1 in the grant cycle: complete immediately and stay in IDLE.
- BUSY:
  - c_req_o=1; c_addr/wdata/wstrb come from the captures, so requester input changes are ignored.
  - The other requester waits, with its ack held 0.
- Completion (c_ack_i=1 while owner is granted/busy):
  - r<owner>_ack_o=1 for that cycle only; r<owner>_rdata_o=c_rdata_i.
  - prio <= ~owner; state <= IDLE.
  - No new grant on the completion cycle; the next grant is evaluated the following cycle (one bubble between transactions).
- Non-owner outputs: r*_ack_o=0 and r*_rdata_o=0 always.
- c_ack_i in IDLE with no grant: ignored, no requester ack.
- Owner dropping req before ack (protocol violation): transaction still completes from the captures and the ack pulse is still issued.
- Reset mid-BUSY: transaction abandoned, no ack issued, priority returns to r0.
- Fairness: with both requesters continuously requesting, grants alternate strictly, so each waits at most one transaction.

Optional Feature:
- Macro IOB_CACHE_ARB_CNT_EN.
- Defined:
  - Adds ports cnt_clr_i (in 1), r0_cnt_o (out 32), r1_cnt_o (out 32).
  - Each counter increments by 1 on each completion (ack) of its requester and wraps from 0xFFFFFFFF to 0.
  - cnt_clr_i=1 synchronously zeroes both counters; clear wins over a same-cycle increment.
  - Reset zeroes both counters.
- Undefined: ports and counters absent; all other behaviour identical.

Test Plan:
- r0 read only, addr 0x40, cache acks 2 cycles after req with rdata 0xDEADBEEF -> c_req_o high 3 cycles, c_addr_o=0x40 throughout, r0_ack_o one pulse with r0_rdata_o=0xDEADBEEF, r1_ack_o=0.
- Both req same cycle after reset, r0 addr 0x10, r1 addr 0x20, r1 wstrb 0xF -> r0 served first; r1 granted in the cycle after r0's ack (bubble); c_addr_o=0x20 with c_wstrb_o=0xF; prio ends at 0.
- Both held continuously for 6 transactions -> grant order r0,r1,r0,r1,r0,r1.
- r1 granted at addr 0x80, then r1_addr_i changed to 0xC0 while BUSY -> c_addr_o stays 0x80 until ack.
- c_ack_i=1 in the grant cycle for r1 -> r1_ack_o pulses that cycle, state stays IDLE, next tie goes to r0.
- reset_n pulled low while BUSY -> outputs 0 immediately, no ack; with IOB_CACHE_ARB_CNT_EN, after 3 r0 and 2 r1 completions r0_cnt_o=3, r1_cnt_o=2, cnt_clr_i zeroes both.

Source files
------------

// File: rtl/iob_cache_front_arbiter.sv
// Two-requester round-robin arbiter in front of a cache req/ack port.
// Optional macro IOB_CACHE_ARB_CNT_EN adds per-requester completion counters.
module iob_cache_front_arbiter #(
   parameter int ADDR_W   = 32,
   parameter int DATA_W   = 32,
   parameter int NBYTES   = DATA_W / 8,
   parameter int USE_CTRL = 0
) (
   input  logic                         clk_i,
   input  logic                         reset_n,
`ifdef IOB_CACHE_ARB_CNT_EN
   input  logic                         cnt_clr_i,
   output logic [31:0]                  r0_cnt_o,
   output logic [31:0]                  r1_cnt_o,
`endif
   input  logic                         r0_req_i,
   input  logic [USE_CTRL+ADDR_W-1:0]   r0_addr_i,
   input  logic [DATA_W-1:0]            r0_wdata_i,
   input  logic [NBYTES-1:0]            r0_wstrb_i,
   output logic [DATA_W-1:0]            r0_rdata_o,
   output logic                         r0_ack_o,
   input  logic                         r1_req_i,
   input  logic [USE_CTRL+ADDR_W-1:0]   r1_addr_i,
   input  logic [DATA_W-1:0]            r1_wdata_i,
   input  logic [NBYTES-1:0]            r1_wstrb_i,
   output logic [DATA_W-1:0]            r1_rdata_o,
   output logic                         r1_ack_o,
   output logic                         c_req_o,
   output logic [USE_CTRL+ADDR_W-1:0]   c_addr_o,
   output logic [DATA_W-1:0]            c_wdata_o,
   output logic [NBYTES-1:0]            c_wstrb_o,
   input  logic [DATA_W-1:0]            c_rdata_i,
   input  logic                         c_ack_i
);

   localparam int AW = USE_CTRL + ADDR_W;

   typedef enum logic {
      S_IDLE = 1'b0,
      S_BUSY = 1'b1
   } state_t;

   state_t              r_state;
   state_t              w_state_nxt;
   logic                r_owner;
   logic                r_prio;
   logic [AW-1:0]       r_addr;
   logic [DATA_W-1:0]   r_wdata;
   logic [NBYTES-1:0]   r_wstrb;

   logic                w_grant;
   logic                w_sel;
   logic                w_cur_owner;
   logic                w_done;

   // NOTE: every signal written here gets a default first, so no path leaves
   // one unassigned and no latch is inferred.
   always_comb begin
      w_state_nxt = r_state;
      w_grant     = 1'b0;
      w_sel       = 1'b0;
      w_cur_owner = r_owner;
      c_req_o     = 1'b0;
      c_addr_o    = '0;
      c_wdata_o   = '0;
      c_wstrb_o   = '0;
      case (r_state)
         S_IDLE: begin
            // Gated by reset_n so an asserted reset forces a quiet bus even
            // while requesters keep their request raised.
            if (reset_n && (r0_req_i || r1_req_i)) begin
               w_grant     = 1'b1;
               w_sel       = (r0_req_i && r1_req_i) ? r_prio : r1_req_i;
               w_cur_owner = w_sel;
               c_req_o     = 1'b1;
               if (w_sel) begin
                  c_addr_o  = r1_addr_i;
                  c_wdata_o = r1_wdata_i;
                  c_wstrb_o = r1_wstrb_i;
               end else begin
                  c_addr_o  = r0_addr_i;
                  c_wdata_o = r0_wdata_i;
                  c_wstrb_o = r0_wstrb_i;
               end
               if (!c_ack_i) w_state_nxt = S_BUSY;
            end
         end
         S_BUSY: begin
            c_req_o   = 1'b1;
            c_addr_o  = r_addr;
            c_wdata_o = r_wdata;
            c_wstrb_o = r_wstrb;
            if (c_ack_i) w_state_nxt = S_IDLE;
         end
         default: w_state_nxt = S_IDLE;
      endcase
      w_done = c_req_o && c_ack_i;
   end

   assign r0_ack_o   = w_done & ~w_cur_owner;
   assign r1_ack_o   = w_done &  w_cur_owner;
   assign r0_rdata_o = r0_ack_o ? c_rdata_i : '0;
   assign r1_rdata_o = r1_ack_o ? c_rdata_i : '0;

   // NOTE: sequential state uses non-blocking assignments so every register
   // samples pre-edge values regardless of statement order.
   always_ff @(posedge clk_i or negedge reset_n) begin
      if (!reset_n) begin
         r_state <= S_IDLE;
         r_owner <= 1'b0;
         r_prio  <= 1'b0;
         r_addr  <= '0;
         r_wdata <= '0;
         r_wstrb <= '0;
      end else begin
         r_state <= w_state_nxt;
         if (w_grant) begin
            r_owner <= w_sel;
            r_addr  <= c_addr_o;
            r_wdata <= c_wdata_o;
            r_wstrb <= c_wstrb_o;
         end
         // The requester just served loses the tie on the next arbitration.
         if (w_done) r_prio <= ~w_cur_owner;
      end
   end

`ifdef IOB_CACHE_ARB_CNT_EN
   logic [31:0] r_cnt0;
   logic [31:0] r_cnt1;

   always_ff @(posedge clk_i or negedge reset_n) begin
      if (!reset_n) begin
         r_cnt0 <= '0;
         r_cnt1 <= '0;
      end else if (cnt_clr_i) begin
         r_cnt0 <= '0;
         r_cnt1 <= '0;
      end else begin
         if (r0_ack_o) r_cnt0 <= r_cnt0 + 32'd1;
         if (r1_ack_o) r_cnt1 <= r_cnt1 + 32'd1;
      end
   end

   assign r0_cnt_o = r_cnt0;
   assign r1_cnt_o = r_cnt1;
`endif

endmodule

// File: tb/tb_iob_cache_front_arbiter.sv
// Randomized scoreboard bench for iob_cache_front_arbiter; a transaction-level
// model predicts grants and completions, a negedge monitor checks the DUT.
module tb_iob_cache_front_arbiter;

   localparam int AW = 32;
   localparam int DW = 32;
   localparam int NB = 4;

   typedef struct {
      bit            who;
      logic [AW-1:0] addr;
      logic [DW-1:0] wdata;
      logic [NB-1:0] wstrb;
      logic [DW-1:0] rdata;
   } txn_t;

   logic          clk = 1'b0;
   logic          reset_n;
   logic          r0_req_i, r1_req_i;
   logic [AW-1:0] r0_addr_i, r1_addr_i;
   logic [DW-1:0] r0_wdata_i, r1_wdata_i;
   logic [NB-1:0] r0_wstrb_i, r1_wstrb_i;
   logic [DW-1:0] r0_rdata_o, r1_rdata_o;
   logic          r0_ack_o, r1_ack_o;
   logic          c_req_o;
   logic [AW-1:0] c_addr_o;
   logic [DW-1:0] c_wdata_o;
   logic [NB-1:0] c_wstrb_o;
   logic [DW-1:0] c_rdata_i;
   logic          c_ack_i;
`ifdef IOB_CACHE_ARB_CNT_EN
   logic          cnt_clr_i;
   logic [31:0]   r0_cnt_o, r1_cnt_o;
   logic [31:0]   exp_cnt0, exp_cnt1;
`endif

   always #5 clk = ~clk;

   iob_cache_front_arbiter #(
      .ADDR_W   (32),
      .DATA_W   (32),
      .USE_CTRL (0)
   ) dut (
      .clk_i      (clk),
      .reset_n    (reset_n),
`ifdef IOB_CACHE_ARB_CNT_EN
      .cnt_clr_i  (cnt_clr_i),
      .r0_cnt_o   (r0_cnt_o),
      .r1_cnt_o   (r1_cnt_o),
`endif
      .r0_req_i   (r0_req_i),
      .r0_addr_i  (r0_addr_i),
      .r0_wdata_i (r0_wdata_i),
      .r0_wstrb_i (r0_wstrb_i),
      .r0_rdata_o (r0_rdata_o),
      .r0_ack_o   (r0_ack_o),
      .r1_req_i   (r1_req_i),
      .r1_addr_i  (r1_addr_i),
      .r1_wdata_i (r1_wdata_i),
      .r1_wstrb_i (r1_wstrb_i),
      .r1_rdata_o (r1_rdata_o),
      .r1_ack_o   (r1_ack_o),
      .c_req_o    (c_req_o),
      .c_addr_o   (c_addr_o),
      .c_wdata_o  (c_wdata_o),
      .c_wstrb_o  (c_wstrb_o),
      .c_rdata_i  (c_rdata_i),
      .c_ack_i    (c_ack_i)
   );

   int n_checks = 0;
   int n_fail   = 0;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Scoreboard: one entry per granted transaction, popped on its ack.
   txn_t exp_q[$];

   // Requester-side and transaction-level model state.
   txn_t          cur [2];
   bit            req [2];
   bit            pend[2];
   bit            done[2];
   bit            m_busy, m_owner, m_prio;
   int            m_lat, m_cnt;
   logic [DW-1:0] m_rdata;

   task automatic drive();
      r0_req_i   = req[0];
      r0_addr_i  = cur[0].addr;
      r0_wdata_i = cur[0].wdata;
      r0_wstrb_i = cur[0].wstrb;
      r1_req_i   = req[1];
      r1_addr_i  = cur[1].addr;
      r1_wdata_i = cur[1].wdata;
      r1_wstrb_i = cur[1].wstrb;
   endtask

   task automatic model_reset();
      exp_q.delete();
      m_busy  = 1'b0;
      m_owner = 1'b0;
      m_prio  = 1'b0;
      m_lat   = 0;
      m_cnt   = 0;
      for (int i = 0; i < 2; i++) begin
         pend[i] = 1'b0;
         done[i] = 1'b0;
      end
   endtask

   // One clock of stimulus; pct is the chance (%) an idle requester starts a new request.
   task automatic step(input int pct);
      bit w;
      @(posedge clk);
      #1;
      c_ack_i   = 1'b0;
      c_rdata_i = $urandom;
`ifdef IOB_CACHE_ARB_CNT_EN
      cnt_clr_i = ($urandom_range(0, 49) == 0);
`endif
      for (int i = 0; i < 2; i++) begin
         if (done[i]) begin
            pend[i] = 1'b0;
            done[i] = 1'b0;
            req[i]  = 1'b0;
         end
         if (!pend[i] && ($urandom_range(1, 100) <= pct)) begin
            cur[i].who   = bit'(i);
            cur[i].addr  = $urandom;
            cur[i].wdata = $urandom;
            cur[i].wstrb = NB'($urandom_range(0, 15));
            cur[i].rdata = $urandom;
            pend[i] = 1'b1;
            req[i]  = 1'b1;
         end else if (pend[i] && m_busy && (m_owner == bit'(i)) && ($urandom_range(0, 2) == 0)) begin
            // Owner changes its inputs (and sometimes drops req) while being served.
            cur[i].addr  = $urandom;
            cur[i].wdata = $urandom;
            cur[i].wstrb = NB'($urandom_range(0, 15));
            if ($urandom_range(0, 3) == 0) req[i] = 1'b0;
         end
      end
      if (!m_busy && (req[0] || req[1])) begin
         w = (req[0] && req[1]) ? m_prio : req[1];
         exp_q.push_back(cur[w]);
         m_busy  = 1'b1;
         m_owner = w;
         m_rdata = cur[w].rdata;
         m_lat   = $urandom_range(0, 3);
         m_cnt   = 0;
      end
      if (m_busy) begin
         if (m_cnt == m_lat) begin
            c_ack_i       = 1'b1;
            c_rdata_i     = m_rdata;
            m_prio        = !m_owner;
            m_busy        = 1'b0;
            done[m_owner] = 1'b1;
         end else begin
            m_cnt++;
         end
      end else if ($urandom_range(0, 3) == 0) begin
         c_ack_i = 1'b1;
      end
      drive();
   endtask

   // Reset asserted in the middle of a transaction with requests and c_ack_i still high.
   task automatic reset_mid_busy();
      for (int k = 0; k < 200 && !m_busy; k++) step(60);
      check("reach_busy_before_reset", m_busy, 1'b1);
      @(posedge clk);
      #1;
      reset_n = 1'b0;
      c_ack_i = 1'b1;
      model_reset();
      repeat (2) @(posedge clk);
      #1;
      for (int i = 0; i < 2; i++) req[i] = 1'b0;
      c_ack_i = 1'b0;
      drive();
      reset_n = 1'b1;
   endtask

   txn_t mon_e;
   always @(negedge clk) begin
      if (!reset_n) begin
         check("rst_c_req",   c_req_o,   1'b0);
         check("rst_c_addr",  c_addr_o,  '0);
         check("rst_c_wdata", c_wdata_o, '0);
         check("rst_c_wstrb", c_wstrb_o, '0);
         check("rst_acks",    {r0_ack_o, r1_ack_o}, 2'b00);
         check("rst_rdata",   {r0_rdata_o, r1_rdata_o}, 64'h0);
`ifdef IOB_CACHE_ARB_CNT_EN
         exp_cnt0 = '0;
         exp_cnt1 = '0;
         check("rst_cnt", {r0_cnt_o, r1_cnt_o}, 64'h0);
`endif
      end else begin
         check("c_req_active", c_req_o, exp_q.size() > 0);
         if (c_req_o && exp_q.size() > 0) begin
            check("c_addr",  c_addr_o,  exp_q[0].addr);
            check("c_wdata", c_wdata_o, exp_q[0].wdata);
            check("c_wstrb", c_wstrb_o, exp_q[0].wstrb);
         end else if (!c_req_o) begin
            check("idle_c_addr",  c_addr_o,  '0);
            check("idle_c_wdata", c_wdata_o, '0);
            check("idle_c_wstrb", c_wstrb_o, '0);
         end
         check("ack_exclusive", r0_ack_o & r1_ack_o, 1'b0);
`ifdef IOB_CACHE_ARB_CNT_EN
         check("r0_cnt", r0_cnt_o, exp_cnt0);
         check("r1_cnt", r1_cnt_o, exp_cnt1);
         if (cnt_clr_i) begin
            exp_cnt0 = '0;
            exp_cnt1 = '0;
         end else begin
            if (r0_ack_o) exp_cnt0 = exp_cnt0 + 32'd1;
            if (r1_ack_o) exp_cnt1 = exp_cnt1 + 32'd1;
         end
`endif
         if (r0_ack_o || r1_ack_o) begin
            check("ack_has_txn", exp_q.size() > 0, 1'b1);
            if (exp_q.size() > 0) begin
               mon_e = exp_q.pop_front();
               check("ack_c_ack",  c_ack_i,  1'b1);
               check("ack_owner",  r1_ack_o, mon_e.who);
               check("ack_rdata",  mon_e.who ? r1_rdata_o : r0_rdata_o, mon_e.rdata);
               check("other_rdata", mon_e.who ? r0_rdata_o : r1_rdata_o, '0);
            end
         end else begin
            check("no_ack_rdata", {r0_rdata_o, r1_rdata_o}, 64'h0);
         end
      end
   end

   initial begin
      reset_n   = 1'b0;
      c_ack_i   = 1'b0;
      c_rdata_i = '0;
`ifdef IOB_CACHE_ARB_CNT_EN
      cnt_clr_i = 1'b0;
      exp_cnt0  = '0;
      exp_cnt1  = '0;
`endif
      for (int i = 0; i < 2; i++) begin
         cur[i] = '{who: bit'(i), addr: '0, wdata: '0, wstrb: '0, rdata: '0};
         req[i] = 1'b0;
      end
      model_reset();
      drive();
      repeat (3) @(posedge clk);
      #1;
      reset_n = 1'b1;

      repeat (1500) step(50);   // mixed traffic, ties and idle gaps
      repeat (300)  step(100);  // both requesters saturated: strict alternation
      reset_mid_busy();
      repeat (1500) step(30);
      for (int k = 0; k < 100 && (m_busy || pend[0] || pend[1]); k++) step(0);
      @(negedge clk);
      #1;
      check("drain_model_idle", {m_busy, pend[0], pend[1]}, 3'b000);
      check("drain_queue_empty", exp_q.size(), 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
